// File: rtl/booth_mult_sequencer.sv
// rtl/booth_mult_sequencer.sv - radix-4 Booth multiply sequencer, 16 iterations, optional overflow shadow (BOOTH_OVERFLOW_EN)
module booth_mult_sequencer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] multiplicand,
    input  logic [31:0] multiplier,
    output logic [2:0]  booth_operation,
    output logic [31:0] shifted_multiplicand,
    input  logic [31:0] partial_product,
    output logic        busy,
    output logic        result_ready,
    output logic [31:0] result,
    output logic        overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] m_q;
    logic [31:0] r_q;
    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [3:0]  count_q;
    logic        busy_q;
    logic        result_ready_q;
    logic [31:0] result_q;

    // Bit position of the current triplet's middle bit; R[-1] is modelled by the appended zero.
    logic [5:0]  bit_idx;
    logic [32:0] r_ext;

    assign bit_idx = {1'b0, count_q, 1'b0};
    assign r_ext   = {r_q, 1'b0};
    assign acc_d   = acc_q + partial_product;

    // Decoder drive: current triplet and M << 2i while iterating, quiet zeros otherwise.
    always_comb begin
        booth_operation      = 3'b000;
        shifted_multiplicand = 32'd0;
        if (state_q == S_RUN) begin
            booth_operation      = r_ext[bit_idx +: 3];
            shifted_multiplicand = m_q << bit_idx[4:0];
        end
    end

`ifdef BOOTH_OVERFLOW_EN
    logic [63:0] shadow_q;
    logic [63:0] shadow_d;
    logic [63:0] m_wide;
    logic [63:0] term;
    logic        overflow_q;
    logic        ovf_d;

    // Full-width mirror of the accumulation so the upper product bits are known at completion.
    always_comb begin
        m_wide = {{32{m_q[31]}}, m_q} << bit_idx[4:0];
        term   = 64'd0;
        case (booth_operation)
            3'b001, 3'b010: term = m_wide;
            3'b011:         term = m_wide << 1;
            3'b100:         term = -(m_wide << 1);
            3'b101, 3'b110: term = -m_wide;
            default:        term = 64'd0;
        endcase
        shadow_d = shadow_q + term;
        // Representable in signed 32 bits only if bits 63..31 are all copies of the sign.
        ovf_d    = ~((&shadow_d[63:31]) | ~(|shadow_d[63:31]));
    end

    // Shadow accumulator and overflow flag follow the main sequencer's phases.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q   <= 64'd0;
            overflow_q <= 1'b0;
        end else begin
            if (state_q == S_RUN) begin
                shadow_q <= shadow_d;
                if (count_q == 4'd15) begin
                    overflow_q <= ovf_d;
                end
            end else if (start) begin
                shadow_q <= 64'd0;
            end
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

    // Main sequencer: accept operands, run 16 accumulate steps, pulse completion.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            m_q            <= 32'd0;
            r_q            <= 32'd0;
            acc_q          <= 32'd0;
            count_q        <= 4'd0;
            busy_q         <= 1'b0;
            result_ready_q <= 1'b0;
            result_q       <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    result_ready_q <= 1'b0;
                    if (start) begin
                        m_q     <= multiplicand;
                        r_q     <= multiplier;
                        acc_q   <= 32'd0;
                        count_q <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_q   <= acc_d;
                    count_q <= count_q + 4'd1;
                    if (count_q == 4'd15) begin
                        result_q       <= acc_d;
                        busy_q         <= 1'b0;
                        result_ready_q <= 1'b1;
                        state_q        <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign result_ready = result_ready_q;
    assign result       = result_q;

endmodule
